// File: rtl/axi_write_arbiter_if.sv
// ============================================================================
// Module      : axi_write_arbiter_if
// Description : Request, handshake and grant signals of the two-master AXI
//               write arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_write_arbiter_if #(
   parameter int LEN_BITS = 4
);
   logic                AWVALID_M0;
   logic                AWVALID_M1;
   logic [LEN_BITS-1:0] AWLEN_M0;
   logic [LEN_BITS-1:0] AWLEN_M1;
   logic                AWVALID;
   logic                AWREADY;
   logic                WVALID;
   logic                WREADY;
   logic                WLAST;
   logic                BVALID;
   logic                BREADY;
   logic [1:0]          aw_gnt;
   logic [1:0]          w_gnt;
   logic [1:0]          b_gnt;
   logic                busy;
   logic                len_err;
   logic                timeout;

   // Environment side: masters, muxes and slave.
   modport master (
      output AWVALID_M0, AWVALID_M1, AWLEN_M0, AWLEN_M1,
      output AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
      input  aw_gnt, w_gnt, b_gnt, busy, len_err, timeout
   );

   // Arbiter side.
   modport slave (
      input  AWVALID_M0, AWVALID_M1, AWLEN_M0, AWLEN_M1,
      input  AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
      output aw_gnt, w_gnt, b_gnt, busy, len_err, timeout
   );
endinterface

`default_nettype wire

// File: rtl/axi_write_arbiter.sv
// ============================================================================
// Module      : axi_write_arbiter
// Description : Two-master AXI write-path sequencer (AW -> W -> B) with
//               burst-length check and stall watchdog. Define
//               AXI_WRITE_ARB_RR_EN for round-robin arbitration.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_write_arbiter #(
   parameter int LEN_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_BITS       = 9
) (
   input  wire logic          ACLK,
   input  wire logic          ARESET,
   axi_write_arbiter_if.slave bus_io
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam bit                WD_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_BITS-1:0] WD_LAST =
      CNT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [1:0]          state_q, state_d;
   logic                winner_q, winner_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [LEN_BITS-1:0] beat_q, beat_d;
   logic [CNT_BITS-1:0] wdog_q, wdog_d;
   logic                len_err_q, len_err_d;
   logic                timeout_q, timeout_d;
   logic [1:0]          aw_gnt_q, w_gnt_q, b_gnt_q;
   logic                busy_q;

   logic                w_hs;
   logic                w_any_req;
   logic                w_pick;
   logic                w_cnt_last;
   logic                w_expire;
   logic [1:0]          w_sel;

   always_comb begin
      w_hs = 1'b0;
      case (state_q)
         S_ADDR:  w_hs = bus_io.AWVALID & bus_io.AWREADY;
         S_DATA:  w_hs = bus_io.WVALID  & bus_io.WREADY;
         S_RESP:  w_hs = bus_io.BVALID  & bus_io.BREADY;
         default: w_hs = 1'b0;
      endcase
   end

   assign w_any_req  = bus_io.AWVALID_M0 | bus_io.AWVALID_M1;
   assign w_cnt_last = (beat_q == len_q);
   assign w_expire   = WD_EN && (state_q != S_IDLE) && !w_hs && (wdog_q == WD_LAST);

`ifdef AXI_WRITE_ARB_RR_EN
   logic rr_q, rr_d;
   logic w_done;

   // A lone requester wins; on contention the pointer picks.
   assign w_pick = (bus_io.AWVALID_M0 & bus_io.AWVALID_M1) ? rr_q : bus_io.AWVALID_M1;
   assign w_done = ((state_q == S_RESP) & w_hs) | w_expire;
   assign rr_d   = w_done ? ~winner_q : rr_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) rr_q <= 1'b0;
      else        rr_q <= rr_d;
   end
`else
   assign w_pick = ~bus_io.AWVALID_M0;
`endif

   always_comb begin
      state_d   = state_q;
      winner_d  = winner_q;
      len_d     = len_q;
      beat_d    = beat_q;
      wdog_d    = wdog_q;
      len_err_d = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_any_req) begin
               winner_d = w_pick;
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (w_hs) begin
               len_d   = winner_q ? bus_io.AWLEN_M1 : bus_io.AWLEN_M0;
               beat_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (w_hs) begin
               beat_d = beat_q + 1'b1;
               // Either WLAST or the counted length ends the burst; disagreement is flagged.
               if (bus_io.WLAST | w_cnt_last) state_d = S_RESP;
               len_err_d = bus_io.WLAST ^ w_cnt_last;
            end
         end
         default: begin
            if (w_hs) state_d = S_IDLE;
         end
      endcase

      if (WD_EN && (state_q != S_IDLE)) wdog_d = w_hs ? '0 : wdog_q + 1'b1;

      if (w_expire) begin
         state_d   = S_IDLE;
         wdog_d    = '0;
         timeout_d = 1'b1;
      end
   end

   assign w_sel = winner_d ? 2'b10 : 2'b01;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         winner_q  <= 1'b0;
         len_q     <= '0;
         beat_q    <= '0;
         wdog_q    <= '0;
         len_err_q <= 1'b0;
         timeout_q <= 1'b0;
         aw_gnt_q  <= 2'b00;
         w_gnt_q   <= 2'b00;
         b_gnt_q   <= 2'b00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         wdog_q    <= wdog_d;
         len_err_q <= len_err_d;
         timeout_q <= timeout_d;
         aw_gnt_q  <= (state_d == S_ADDR) ? w_sel : 2'b00;
         w_gnt_q   <= (state_d == S_DATA) ? w_sel : 2'b00;
         b_gnt_q   <= (state_d == S_RESP) ? w_sel : 2'b00;
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign bus_io.aw_gnt  = aw_gnt_q;
   assign bus_io.w_gnt   = w_gnt_q;
   assign bus_io.b_gnt   = b_gnt_q;
   assign bus_io.busy    = busy_q;
   assign bus_io.len_err = len_err_q;
   assign bus_io.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
// ============================================================================
// Module      : tb_axi_write_arbiter
// Description : Directed self-checking bench for axi_write_arbiter
//               (watchdog shortened to 8 cycles).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_write_arbiter;

   logic ACLK = 1'b0;
   logic ARESET;
   int   n_cmp = 0;
   int   n_err = 0;

   axi_write_arbiter_if #(.LEN_BITS(4)) bus ();

   axi_write_arbiter #(
      .LEN_BITS       (4),
      .TIMEOUT_CYCLES (8),
      .CNT_BITS       (4)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus_io (bus)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_all();
      bus.AWVALID_M0 = 1'b0;
      bus.AWVALID_M1 = 1'b0;
      bus.AWLEN_M0   = 4'd0;
      bus.AWLEN_M1   = 4'd0;
      bus.AWVALID    = 1'b0;
      bus.AWREADY    = 1'b0;
      bus.WVALID     = 1'b0;
      bus.WREADY     = 1'b0;
      bus.WLAST      = 1'b0;
      bus.BVALID     = 1'b0;
      bus.BREADY     = 1'b0;
   endtask

   // One full transaction from IDLE; requests must already be set by the caller.
   task automatic txn(input string tag, input logic [1:0] exp_g, input int nbeats,
                      input int wlast_at, input logic exp_lerr);
      step();
      chk_eq({tag, "_aw"}, bus.aw_gnt, exp_g);
      chk_eq({tag, "_busy"}, bus.busy, 1'b1);
      bus.AWVALID = 1'b1; bus.AWREADY = 1'b1;
      step();
      bus.AWVALID = 1'b0; bus.AWREADY = 1'b0;
      chk_eq({tag, "_w"}, bus.w_gnt, exp_g);
      chk_eq({tag, "_aw_off"}, bus.aw_gnt, 2'b00);
      for (int i = 1; i <= nbeats; i++) begin
         bus.WVALID = 1'b1; bus.WREADY = 1'b1; bus.WLAST = (i == wlast_at);
         step();
      end
      bus.WVALID = 1'b0; bus.WREADY = 1'b0; bus.WLAST = 1'b0;
      chk_eq({tag, "_b"}, bus.b_gnt, exp_g);
      chk_eq({tag, "_w_off"}, bus.w_gnt, 2'b00);
      chk_eq({tag, "_lerr"}, bus.len_err, exp_lerr);
      bus.BVALID = 1'b1; bus.BREADY = 1'b1;
      step();
      bus.BVALID = 1'b0; bus.BREADY = 1'b0;
      chk_eq({tag, "_b_off"}, bus.b_gnt, 2'b00);
      chk_eq({tag, "_idle"}, bus.busy, 1'b0);
      chk_eq({tag, "_lerr_end"}, bus.len_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [1:0] arb_exp [3];
`ifdef AXI_WRITE_ARB_RR_EN
      arb_exp = '{2'b01, 2'b10, 2'b01};
`else
      arb_exp = '{2'b01, 2'b01, 2'b01};
`endif

      ARESET = 1'b1;
      idle_all();
      step();
      step();
      chk_eq("rst_aw", bus.aw_gnt, 2'b00);
      chk_eq("rst_w", bus.w_gnt, 2'b00);
      chk_eq("rst_b", bus.b_gnt, 2'b00);
      chk_eq("rst_busy", bus.busy, 1'b0);
      chk_eq("rst_lerr", bus.len_err, 1'b0);
      chk_eq("rst_tmo", bus.timeout, 1'b0);
      ARESET = 1'b0;
      step();
      chk_eq("idle_noreq", bus.busy, 1'b0);

      // M1 alone, 4 beats with WLAST on the 4th.
      bus.AWVALID_M1 = 1'b1; bus.AWLEN_M1 = 4'd3;
      txn("m1_len3", 2'b10, 4, 4, 1'b0);
      bus.AWVALID_M1 = 1'b0;

      // Both masters contending for three single-beat transactions.
      bus.AWVALID_M0 = 1'b1; bus.AWLEN_M0 = 4'd0;
      bus.AWVALID_M1 = 1'b1; bus.AWLEN_M1 = 4'd0;
      for (int t = 0; t < 3; t++) txn($sformatf("arb%0d", t), arb_exp[t], 1, 1, 1'b0);
      bus.AWVALID_M0 = 1'b0; bus.AWVALID_M1 = 1'b0;

      // Early WLAST: AWLEN 3, WLAST on beat 2.
      bus.AWVALID_M0 = 1'b1; bus.AWLEN_M0 = 4'd3;
      txn("early_last", 2'b01, 2, 2, 1'b1);
      // Missing WLAST: AWLEN 1, counter ends the burst after 2 beats.
      bus.AWLEN_M0 = 4'd1;
      txn("no_last", 2'b01, 2, 0, 1'b1);
      bus.AWVALID_M0 = 1'b0;

      // Watchdog: B never arrives.
      bus.AWVALID_M0 = 1'b1; bus.AWLEN_M0 = 4'd0;
      step();
      chk_eq("wd_aw", bus.aw_gnt, 2'b01);
      bus.AWVALID_M0 = 1'b0;
      bus.AWVALID = 1'b1; bus.AWREADY = 1'b1;
      step();
      bus.AWVALID = 1'b0; bus.AWREADY = 1'b0;
      bus.WVALID = 1'b1; bus.WREADY = 1'b1; bus.WLAST = 1'b1;
      step();
      bus.WVALID = 1'b0; bus.WREADY = 1'b0; bus.WLAST = 1'b0;
      bus.BREADY = 1'b1;
      chk_eq("wd_b", bus.b_gnt, 2'b01);
      repeat (7) step();
      chk_eq("wd_tmo_early", bus.timeout, 1'b0);
      chk_eq("wd_b_held", bus.b_gnt, 2'b01);
      step();
      chk_eq("wd_tmo", bus.timeout, 1'b1);
      chk_eq("wd_b_drop", bus.b_gnt, 2'b00);
      chk_eq("wd_busy", bus.busy, 1'b0);
      step();
      chk_eq("wd_tmo_pulse", bus.timeout, 1'b0);
      bus.BREADY = 1'b0;
      bus.AWVALID_M1 = 1'b1; bus.AWLEN_M1 = 4'd0;
      txn("after_wd", 2'b10, 1, 1, 1'b0);
      bus.AWVALID_M1 = 1'b0;

      // Reset in the middle of a 4-beat burst.
      bus.AWVALID_M1 = 1'b1; bus.AWLEN_M1 = 4'd3;
      step();
      bus.AWVALID_M1 = 1'b0;
      bus.AWVALID = 1'b1; bus.AWREADY = 1'b1;
      step();
      bus.AWVALID = 1'b0; bus.AWREADY = 1'b0;
      bus.WVALID = 1'b1; bus.WREADY = 1'b1;
      step();
      chk_eq("mid_w", bus.w_gnt, 2'b10);
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      bus.WVALID = 1'b0; bus.WREADY = 1'b0;
      chk_eq("mid_rst_aw", bus.aw_gnt, 2'b00);
      chk_eq("mid_rst_w", bus.w_gnt, 2'b00);
      chk_eq("mid_rst_b", bus.b_gnt, 2'b00);
      chk_eq("mid_rst_busy", bus.busy, 1'b0);
      bus.AWVALID_M1 = 1'b1;
      txn("after_rst", 2'b10, 4, 4, 1'b0);
      bus.AWVALID_M1 = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
